// File: rtl/intra_mb_scheduler_if.sv
// Handshake/bus bundle between the frame controller side and intra_mb_scheduler.
// master: drives start/abort/hold/mb_done, observes issue strobe, coordinates and status.
// slave : the scheduler itself (consumes controls, produces issue strobe and status).
interface intra_mb_scheduler_if;
  logic        start;
  logic        abort;
  logic        hold;
  logic        mb_done;
  logic        mb_enable;
  logic [31:0] mb_number;
  logic        busy;
  logic        frame_done;
  logic        error;
  logic [31:0] mb_count;

  modport master (
    output start, abort, hold, mb_done,
    input  mb_enable, mb_number, busy, frame_done, error, mb_count
  );

  modport slave (
    input  start, abort, hold, mb_done,
    output mb_enable, mb_number, busy, frame_done, error, mb_count
  );
endinterface

// File: rtl/intra_mb_scheduler.sv
// Purpose : raster-order macroblock sequencer; issues one MB coordinate per transaction and
//           waits for per-MB completion before advancing.
// Latency : all outputs registered; minimum 3 cycles per MB (ISSUE, WAIT, ADVANCE).
// Backpressure: hold stalls in ISSUE; WAIT blocks until mb_done or TIMEOUT expiry.
// Ports   : clk, reset (async, active-high); bus (slave modport):
//           start/abort/hold/mb_done in; mb_enable, mb_number {row,col}, busy,
//           frame_done, error (sticky timeout), mb_count out.
module intra_mb_scheduler #(
  parameter int WIDTH     = 1280,
  parameter int LENGTH    = 720,
  parameter int MB_SIZE_L = 8,
  parameter int MB_SIZE_W = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  intra_mb_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ADVANCE,
    S_DONE
  } state_t;

  localparam int TW = $clog2(TIMEOUT);
  // Timer value seen in the last permitted WAIT cycle (timer starts at 0 in the first one).
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  // 17-bit limits/steps so the "next position" compare never wraps near 65535.
  localparam logic [16:0] STEP_W = 17'(MB_SIZE_W);
  localparam logic [16:0] STEP_L = 17'(MB_SIZE_L);
  localparam logic [16:0] LIM_W  = 17'(WIDTH);
  localparam logic [16:0] LIM_L  = 17'(LENGTH);

  state_t         state_q, state_d;
  logic [15:0]    row_q, row_d;
  logic [15:0]    col_q, col_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           mb_enable_q, mb_enable_d;
  logic [31:0]    mb_number_q, mb_number_d;
  logic           busy_q, busy_d;
  logic           frame_done_q, frame_done_d;
  logic           error_q, error_d;
  logic [31:0]    mb_count_q, mb_count_d;

  logic [16:0]    col_sum;
  logic [16:0]    row_sum;

  assign col_sum = {1'b0, col_q} + STEP_W;
  assign row_sum = {1'b0, row_q} + STEP_L;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    timer_d      = timer_q;
    mb_enable_d  = 1'b0;
    mb_number_d  = mb_number_q;
    frame_done_d = 1'b0;
    error_d      = error_q;
    mb_count_d   = mb_count_q;

    if (bus.abort) begin
      // Abort outranks start, hold and mb_done; completed-MB count and error are kept.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            row_d      = '0;
            col_d      = '0;
            mb_count_d = '0;
            error_d    = 1'b0;
            state_d    = S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (!bus.hold) begin
            mb_enable_d = 1'b1;
            mb_number_d = {row_q, col_q};
            timer_d     = '0;
            state_d     = S_WAIT;
          end
        end

        S_WAIT: begin
          timer_d = timer_q + 1'b1;
          // mb_done is checked first so a completion on the expiry cycle still counts.
          if (bus.mb_done) begin
            state_d = S_ADVANCE;
          end else if (timer_q == TMO_LAST) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end

        S_ADVANCE: begin
          if (mb_count_q != 32'hFFFF_FFFF) begin
            mb_count_d = mb_count_q + 32'd1;
          end
          if (col_sum < LIM_W) begin
            col_d   = col_sum[15:0];
            state_d = S_ISSUE;
          end else if (row_sum < LIM_L) begin
            col_d   = '0;
            row_d   = row_sum[15:0];
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end

        S_DONE: begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      timer_q      <= '0;
      mb_enable_q  <= 1'b0;
      mb_number_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
      mb_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      timer_q      <= timer_d;
      mb_enable_q  <= mb_enable_d;
      mb_number_q  <= mb_number_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
      mb_count_q   <= mb_count_d;
    end
  end

  assign bus.mb_enable  = mb_enable_q;
  assign bus.mb_number  = mb_number_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.error      = error_q;
  assign bus.mb_count   = mb_count_q;

endmodule
